// File: rtl/seq_pattern_detector.sv
// rtl/seq_pattern_detector.sv - multi-channel serial bit-pattern detector
//
// Purpose:
//   Shifts a serial bit stream into a short history register and compares
//   the newest PAT_LEN bits against NUM_PAT independently configured
//   patterns. Each channel produces a registered one-cycle match pulse and,
//   optionally, a saturating match counter.
//
// Configuration macro:
//   SEQ_PATTERN_DETECTOR_MATCH_CNT_EN - when defined, per-channel match
//   counters and the clr_cnt clear are built; when undefined, cnt is tied
//   to zero and clr_cnt is ignored.
//
// Parameters:
//   PAT_LEN  - pattern length in bits (2..8)
//   NUM_PAT  - number of pattern channels (1..4)
//   CNT_W    - width of each match counter
//
// Ports:
//   clock     in   rising-edge clock
//   reset     in   asynchronous active-high reset
//   i         in   serial data bit
//   valid     in   i is consumed on this edge when high
//   pat_cfg   in   channel k pattern at [k*PAT_LEN +: PAT_LEN], MSB oldest
//   overlap   in   1 = overlapping detection, 0 = restart after a match
//   clr_cnt   in   synchronous clear of all match counters
//   o         out  registered per-channel match pulse
//   match_any out  OR of all o bits
//   cnt       out  channel k counter at [k*CNT_W +: CNT_W]

module seq_pattern_detector #(
    parameter int PAT_LEN = 3,
    parameter int NUM_PAT = 2,
    parameter int CNT_W   = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       i,
    input  logic                       valid,
    input  logic [NUM_PAT*PAT_LEN-1:0] pat_cfg,
    input  logic                       overlap,
    input  logic                       clr_cnt,
    output logic [NUM_PAT-1:0]         o,
    output logic                       match_any,
    output logic [NUM_PAT*CNT_W-1:0]   cnt
);

    // Fill counters only need to reach PAT_LEN-1.
    localparam int              FILL_W   = $clog2(PAT_LEN);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN - 1);

    logic [PAT_LEN-2:0] hist_q, hist_d;
    logic [FILL_W-1:0]  fill_q [NUM_PAT];
    logic [FILL_W-1:0]  fill_d [NUM_PAT];
    logic [NUM_PAT-1:0] o_q, o_d;

    // Window = stored history plus the bit arriving on this edge.
    logic [PAT_LEN-1:0] window;
    logic [NUM_PAT-1:0] hit;

    always_comb begin
        window = {hist_q, i};
        hist_d = valid ? window[PAT_LEN-2:0] : hist_q;
        hit    = '0;
        o_d    = '0;
        for (int k = 0; k < NUM_PAT; k++) begin
            hit[k]    = (fill_q[k] == FILL_MAX) &&
                        (window == pat_cfg[k*PAT_LEN +: PAT_LEN]);
            fill_d[k] = fill_q[k];
            if (valid) begin
                o_d[k] = hit[k];
                if (hit[k] && !overlap) begin
                    // Non-overlapping mode: the next match needs a full
                    // fresh set of PAT_LEN bits.
                    fill_d[k] = '0;
                end else if (fill_q[k] != FILL_MAX) begin
                    fill_d[k] = fill_q[k] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hist_q <= '0;
            o_q    <= '0;
            for (int k = 0; k < NUM_PAT; k++) begin
                fill_q[k] <= '0;
            end
        end else begin
            hist_q <= hist_d;
            o_q    <= o_d;
            for (int k = 0; k < NUM_PAT; k++) begin
                fill_q[k] <= fill_d[k];
            end
        end
    end

    assign o         = o_q;
    assign match_any = |o_q;

`ifdef SEQ_PATTERN_DETECTOR_MATCH_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_q [NUM_PAT];

    // o_d is exactly the value o takes on this edge, so counting it keeps
    // the counter aligned with the pulse. Clear has priority.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_PAT; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_PAT; k++) begin
                if (clr_cnt) begin
                    cnt_q[k] <= '0;
                end else if (o_d[k] && (cnt_q[k] != CNT_MAX)) begin
                    cnt_q[k] <= cnt_q[k] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        cnt = '0;
        for (int k = 0; k < NUM_PAT; k++) begin
            cnt[k*CNT_W +: CNT_W] = cnt_q[k];
        end
    end
`else
    logic unused_clr_cnt;
    assign unused_clr_cnt = clr_cnt;
    assign cnt            = '0;
`endif

endmodule

// File: tb/tb_seq_pattern_detector.sv
// tb/tb_seq_pattern_detector.sv - directed self-checking bench for seq_pattern_detector

module tb_seq_pattern_detector;

`ifdef SEQ_PATTERN_DETECTOR_MATCH_CNT_EN
    localparam bit CE = 1'b1;
`else
    localparam bit CE = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        i;
    logic        valid;
    logic [5:0]  pat_cfg;
    logic        overlap;
    logic        clr_cnt;
    logic [1:0]  o, o2;
    logic        match_any, match_any2;
    logic [15:0] cnt;
    logic [3:0]  cnt2;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    seq_pattern_detector #(.PAT_LEN(3), .NUM_PAT(2), .CNT_W(8)) dut (
        .clock(clock), .reset(reset), .i(i), .valid(valid),
        .pat_cfg(pat_cfg), .overlap(overlap), .clr_cnt(clr_cnt),
        .o(o), .match_any(match_any), .cnt(cnt)
    );

    seq_pattern_detector #(.PAT_LEN(3), .NUM_PAT(2), .CNT_W(2)) dut2 (
        .clock(clock), .reset(reset), .i(i), .valid(valid),
        .pat_cfg(pat_cfg), .overlap(overlap), .clr_cnt(clr_cnt),
        .o(o2), .match_any(match_any2), .cnt(cnt2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ec(input int n);
        return CE ? 32'(n) : 32'd0;
    endfunction

    task automatic push(input logic b);
        i     = b;
        valid = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        valid = 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        valid = 1'b0;
        reset = 1'b1;
        #3;
        reset = 1'b0;
    endtask

    logic [9:0] s_bits;
    logic [9:0] s_m0;
    logic [9:0] s_m1;
    logic [5:0] r_exp;

    initial begin
        reset   = 1'b1;
        i       = 1'b0;
        valid   = 1'b0;
        pat_cfg = {3'b001, 3'b111};
        overlap = 1'b1;
        clr_cnt = 1'b0;
        #2;
        chk("reset_o", 32'(o), 32'd0);
        chk("reset_any", 32'(match_any), 32'd0);
        chk("reset_cnt", 32'(cnt), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // First match on the third bit, pulse lasts one cycle.
        push(1'b1); chk("t1_b1", 32'(o), 32'd0);
        push(1'b1); chk("t1_b2", 32'(o), 32'd0);
        push(1'b1); chk("t1_b3", 32'(o), 32'd1);
        chk("t1_any", 32'(match_any), 32'd1);
        chk("t1_cnt0", 32'(cnt[7:0]), ec(1));
        idle();     chk("t1_pulse_end", 32'(o), 32'd0);
        chk("t1_cnt0_hold", 32'(cnt[7:0]), ec(1));

        // Mixed stream, overlapping mode.
        do_reset();
        s_bits = 10'b1110011001;
        s_m0   = 10'b0010000000;
        s_m1   = 10'b0000010001;
        for (int n = 0; n < 10; n++) begin
            push(s_bits[9-n]);
            chk($sformatf("t2_bit%0d", n + 1), 32'(o), 32'({s_m1[9-n], s_m0[9-n]}));
        end
        chk("t2_cnt0", 32'(cnt[7:0]), ec(1));
        chk("t2_cnt1", 32'(cnt[15:8]), ec(2));

        // Run of ones, overlapping.
        do_reset();
        r_exp = 6'b001111;
        for (int n = 0; n < 6; n++) begin
            push(1'b1);
            chk($sformatf("t3_ov_bit%0d", n + 1), 32'(o), 32'({1'b0, r_exp[5-n]}));
        end
        chk("t3_ov_cnt0", 32'(cnt[7:0]), ec(4));

        // Run of ones, non-overlapping.
        do_reset();
        overlap = 1'b0;
        r_exp   = 6'b001001;
        for (int n = 0; n < 6; n++) begin
            push(1'b1);
            chk($sformatf("t3_nov_bit%0d", n + 1), 32'(o), 32'({1'b0, r_exp[5-n]}));
        end
        chk("t3_nov_cnt0", 32'(cnt[7:0]), ec(2));
        overlap = 1'b1;

        // Valid gaps do not break a partial pattern.
        do_reset();
        push(1'b0); chk("t4_b1", 32'(o), 32'd0);
        for (int n = 0; n < 3; n++) begin
            idle(); chk("t4_gap1", 32'(o), 32'd0);
        end
        push(1'b0); chk("t4_b2", 32'(o), 32'd0);
        for (int n = 0; n < 3; n++) begin
            idle(); chk("t4_gap2", 32'(o), 32'd0);
        end
        push(1'b1); chk("t4_b3", 32'(o), 32'd2);
        chk("t4_any", 32'(match_any), 32'd1);
        idle();     chk("t4_end", 32'(o), 32'd0);

        // Counter saturation (CNT_W=2 instance) and clear-over-increment.
        do_reset();
        for (int n = 0; n < 7; n++) begin
            push(1'b1);
        end
        chk("t5_o", 32'(o2), 32'd1);
        chk("t5_sat", 32'(cnt2[1:0]), ec(3));
        chk("t5_wide", 32'(cnt[7:0]), ec(5));
        clr_cnt = 1'b1;
        push(1'b1);
        clr_cnt = 1'b0;
        chk("t5_clr_o", 32'(o2), 32'd1);
        chk("t5_clr_cnt2", 32'(cnt2[1:0]), 32'd0);
        chk("t5_clr_cnt", 32'(cnt[7:0]), 32'd0);

        // Asynchronous reset mid-cycle discards history.
        do_reset();
        push(1'b1);
        push(1'b1);
        push(1'b1);
        push(1'b1);
        chk("t6_pre_o", 32'(o), 32'd1);
        chk("t6_pre_cnt", 32'(cnt[7:0]), ec(2));
        #2;
        reset = 1'b1;
        #1;
        chk("t6_async_o", 32'(o), 32'd0);
        chk("t6_async_any", 32'(match_any), 32'd0);
        chk("t6_async_cnt", 32'(cnt), 32'd0);
        #1;
        reset = 1'b0;
        push(1'b1); chk("t6_b1", 32'(o), 32'd0);
        push(1'b1); chk("t6_b2", 32'(o), 32'd0);
        push(1'b1); chk("t6_b3", 32'(o), 32'd1);

        // Pattern change takes effect on the next valid edge only.
        pat_cfg = {3'b001, 3'b110};
        push(1'b0); chk("t7_newpat", 32'(o), 32'd1);
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_pattern_detector.md
SEQ_PATTERN_DETECTOR -- requirements
Module: seq_pattern_detector

Interface
REQ-001 Parameter PAT_LEN, default 3, sets the pattern length in bits; legal range 2..8.
REQ-002 Parameter NUM_PAT, default 2, sets the number of independent pattern channels; legal range 1..4.
REQ-003 Parameter CNT_W, default 8, sets the width of each per-channel match counter.
REQ-004 Port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 Port i, input, 1 bit: serial data bit.
REQ-007 Port valid, input, 1 bit: when high, i is consumed on this rising edge.
REQ-008 Port pat_cfg, input, NUM_PAT*PAT_LEN bits: the channel k pattern is slice [k*PAT_LEN +: PAT_LEN], with the MSB as the oldest bit.
REQ-009 Port overlap, input, 1 bit: 1 selects overlapping detection; 0 selects non-overlapping detection.
REQ-010 Port clr_cnt, input, 1 bit: synchronous clear of all match counters.
REQ-011 Port o, output, NUM_PAT bits: registered per-channel match pulse.
REQ-012 Port match_any, output, 1 bit: the OR of all bits of o.
REQ-013 Port cnt, output, NUM_PAT*CNT_W bits: per-channel match counters, with channel k at [k*CNT_W +: CNT_W].

Function
REQ-014 The block SHALL hold a PAT_LEN-1 bit history hist, with the newest bit at hist[0]; on a valid edge, hist <= {hist[PAT_LEN-3:0], i}.
REQ-015 The comparison window SHALL be {hist, i}, compared against each channel pattern on every valid edge.
REQ-016 Each channel SHALL keep a fill counter fill[k] in the range 0..PAT_LEN-1.
REQ-017 A channel SHALL match on a valid edge when fill[k] == PAT_LEN-1 and the window equals pat_k.
REQ-018 On a channel match, o[k] SHALL be 1 for exactly the following cycle, giving a latency of one clock from the edge consuming the final bit.
REQ-019 Fill update on a valid edge: if the channel matched and overlap==0, fill[k] <= 0; otherwise fill[k] <= min(fill[k]+1, PAT_LEN-1).
REQ-020 On an edge with valid low: hist and fill are held, and o <= 0; gaps of any length SHALL NOT break a partial pattern.
REQ-021 Channels are independent; several o bits may be set in the same cycle.
REQ-022 pat_cfg and overlap are sampled combinationally at each valid edge; no retroactive re-evaluation of history takes place.
REQ-023 Counter cnt[k] SHALL increment on the edge that sets o[k] and saturate at 2^CNT_W-1.
REQ-024 clr_cnt high on an edge SHALL zero all counters; clear wins over a simultaneous increment. It does not affect hist, fill or o.

Reset
REQ-025 While reset is high: hist=0, all fill=0, o=0, match_any=0, all cnt=0, applied asynchronously.
REQ-026 After deassertion, the first match is possible no earlier than the PAT_LEN-th valid bit; partial patterns in progress before reset are discarded.

Configuration
REQ-027 Macro SEQ_PATTERN_DETECTOR_MATCH_CNT_EN, when defined, SHALL compile in the counters and clr_cnt logic per REQ-023/024.
REQ-028 Without the macro, no counter flops SHALL exist, cnt SHALL be driven constant 0, and clr_cnt is ignored; all other behaviour is identical.

Verification (PAT_LEN=3, NUM_PAT=2, pat0=111, pat1=001, valid=1 unless stated, macro defined)
REQ-029 Reset, then bits 1,1 -> o=00; third bit 1 -> o[0]=1 for exactly one cycle; cnt0=1.
REQ-030 Stream 1110011001 with overlap=1 -> o[0] pulses after bit 3; o[1] pulses after bits 6 and 10; final cnt0=1, cnt1=2.
REQ-031 Stream 111111: with overlap=1 -> o[0] pulses after bits 3..6 (cnt0=4); with overlap=0 -> pulses after bits 3 and 6 only (cnt0=2).
REQ-032 Bits 0,0,1 with 3 valid-low cycles between each bit -> o stays 00 during the gaps; o[1]=1 one cycle after the final valid edge.
REQ-033 With CNT_W=2, five 111 matches -> cnt0=3 (saturated); clr_cnt asserted on the same edge as a further match -> o[0]=1, cnt0=0.
REQ-034 Bits 1,1, then reset pulsed mid-cycle (asynchronously), then bit 1 -> no match; o=00 and cnt=0 immediately on reset assertion.
